// File: rtl/fifo_2048_2.sv
// fifo_2048_2: output reorder buffer for a radix-2 SDF FFT stage.
// Each y1 goes straight to the output. Each y2 is parked in a block RAM,
// and the whole block of y2 values is replayed in arrival order once
// 2^depth_len pairs have been collected.
module fifo_2048_2 #(
  parameter int float_len = 32,
  parameter int depth_len = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2*float_len-1:0] data_in1,
  input  logic [2*float_len-1:0] data_in2,
  input  logic                   data_in_valid,
  output logic                   in_ready,
  output logic [2*float_len-1:0] data_out,
  output logic                   data_out_valid,
  output logic                   err
);

  localparam int W     = 2 * float_len;
  localparam int DEPTH = 1 << depth_len;

  localparam logic [0:0] FILL  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  localparam logic [depth_len-1:0] WR_LAST    = {depth_len{1'b1}};
  localparam logic [depth_len:0]   DRAIN_LAST = {1'b1, {depth_len{1'b0}}};

  logic [0:0]           state_q, state_d;
  logic [depth_len-1:0] wr_cnt_q, wr_cnt_d;
  logic [depth_len-1:0] rd_cnt_q, rd_cnt_d;
  // Counts DRAIN cycles 0..DEPTH; the extra top bit marks the final
  // cycle, which only flushes the last RAM read to the output.
  logic [depth_len:0]   drain_cnt_q, drain_cnt_d;
  logic [W-1:0]         data_out_q, data_out_d;
  logic                 data_out_valid_q, data_out_valid_d;
  logic                 err_q, err_d;

  logic                 wr_en;
  logic                 rd_en;
  logic [W-1:0]         mem [DEPTH];
  logic [W-1:0]         ram_rd_q;

  // Next-state decode for the FILL/DRAIN sequencer and the output stage
  always_comb begin
    state_d          = state_q;
    wr_cnt_d         = wr_cnt_q;
    rd_cnt_d         = rd_cnt_q;
    drain_cnt_d      = drain_cnt_q;
    data_out_d       = data_out_q;
    data_out_valid_d = 1'b0;
    err_d            = err_q;
    wr_en            = 1'b0;
    rd_en            = 1'b0;
    case (state_q)
      FILL: begin
        if (data_in_valid) begin
          data_out_d       = data_in1;
          data_out_valid_d = 1'b1;
          wr_en            = 1'b1;
          wr_cnt_d         = wr_cnt_q + 1'b1;
          if (wr_cnt_q == WR_LAST) begin
            state_d     = DRAIN;
            drain_cnt_d = '0;
          end
        end
      end
      DRAIN: begin
        // Input is not accepted while draining; remember the violation.
        if (data_in_valid) begin
          err_d = 1'b1;
        end
        // The first DRAIN cycle only issues a read, so no output yet.
        if (drain_cnt_q != '0) begin
          data_out_d       = ram_rd_q;
          data_out_valid_d = 1'b1;
        end
        if (!drain_cnt_q[depth_len]) begin
          rd_en    = 1'b1;
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d     = FILL;
          drain_cnt_d = '0;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // Control and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= FILL;
      wr_cnt_q         <= '0;
      rd_cnt_q         <= '0;
      drain_cnt_q      <= '0;
      data_out_q       <= '0;
      data_out_valid_q <= 1'b0;
      err_q            <= 1'b0;
    end else begin
      state_q          <= state_d;
      wr_cnt_q         <= wr_cnt_d;
      rd_cnt_q         <= rd_cnt_d;
      drain_cnt_q      <= drain_cnt_d;
      data_out_q       <= data_out_d;
      data_out_valid_q <= data_out_valid_d;
      err_q            <= err_d;
    end
  end

  // y2 storage write port; RAM contents are never reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_cnt_q] <= data_in2;
    end
  end

  // Registered read port, one cycle of latency
  always_ff @(posedge clk) begin
    if (rd_en) begin
      ram_rd_q <= mem[rd_cnt_q];
    end
  end

  assign in_ready       = (state_q == FILL);
  assign data_out       = data_out_q;
  assign data_out_valid = data_out_valid_q;
  assign err            = err_q;

endmodule
